gate_truth_checker: RTL

- Self-checking stimulus/response stage for a 2-input combinational gate such as or_gate.
- Upstream side: drives the gate's A/B inputs through all four input combinations.
- Downstream side: samples the gate's C output, compares it against a parameterised truth table, counts mismatches and reports pass/fail.
- Sits beside the gate under test in hardware self-test builds; replaces hand-written per-gate stimulus.

---
 rtl/gate_truth_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// Stimulus/response checker for a 2-input combinational gate: walks {a,b} through
// 00,01,10,11 and compares the gate output against the TRUTH table, counting mismatches.
module gate_truth_checker #(
   parameter logic [3:0]  TRUTH         = 4'b1110,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       gate_c,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic       fail_valid,
   output logic [1:0] fail_vec
);

   // A settle time of zero cannot hold the inputs at all, so it is promoted to one cycle.
   localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd1 : 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [1:0] idx;
   logic [1:0] idx_nxt;
   logic [3:0] settle_cnt;
   logic [3:0] settle_cnt_nxt;
   logic       busy_nxt;
   logic       done_nxt;
   logic       pass_nxt;
   logic [2:0] err_count_nxt;
   logic       fail_valid_nxt;
   logic [1:0] fail_vec_nxt;

   logic       mismatch;
   logic [2:0] err_bumped;
   logic [2:0] err_now;

   assign mismatch   = (gate_c != TRUTH[idx]);
   assign err_bumped = (err_count == 3'd4) ? 3'd4 : err_count + 3'd1;
   assign err_now    = mismatch ? err_bumped : err_count;

   // State register together with every registered output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= 2'd0;
         settle_cnt <= 4'd0;
         gate_a     <= 1'b0;
         gate_b     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 3'd0;
         fail_valid <= 1'b0;
         fail_vec   <= 2'b00;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         settle_cnt <= settle_cnt_nxt;
         gate_a     <= idx_nxt[1];
         gate_b     <= idx_nxt[0];
         busy       <= busy_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         err_count  <= err_count_nxt;
         fail_valid <= fail_valid_nxt;
         fail_vec   <= fail_vec_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = SETTLE;
         SETTLE:     if (settle_cnt <= 4'd1) state_nxt = SAMPLE;
         SAMPLE:     state_nxt = (idx == 2'd3) ? DONE : SETTLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Datapath updates; results persist in DONE until the next start clears them.
   always_comb begin
      idx_nxt        = idx;
      settle_cnt_nxt = settle_cnt;
      busy_nxt       = busy;
      done_nxt       = done;
      pass_nxt       = pass;
      err_count_nxt  = err_count;
      fail_valid_nxt = fail_valid;
      fail_vec_nxt   = fail_vec;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               idx_nxt        = 2'd0;
               settle_cnt_nxt = SETTLE_LOAD;
               err_count_nxt  = 3'd0;
               fail_valid_nxt = 1'b0;
               fail_vec_nxt   = 2'b00;
               done_nxt       = 1'b0;
               pass_nxt       = 1'b0;
               busy_nxt       = 1'b1;
            end
         end
         SETTLE: begin
            if (settle_cnt > 4'd1) settle_cnt_nxt = settle_cnt - 4'd1;
         end
         SAMPLE: begin
            err_count_nxt = err_now;
            if (mismatch && !fail_valid) begin
               fail_valid_nxt = 1'b1;
               fail_vec_nxt   = idx;
            end
            if (idx == 2'd3) begin
               busy_nxt = 1'b0;
               done_nxt = 1'b1;
               pass_nxt = (err_now == 3'd0);
            end else begin
               idx_nxt        = idx + 2'd1;
               settle_cnt_nxt = SETTLE_LOAD;
            end
         end
         default: ;
      endcase
   end

endmodule
